// File: rtl/charmap_pipe.sv
// Pipelined character-map renderer: raster counters -> char RAM / glyph ROM
// fetch addresses -> one RGB888+alpha pixel per pixel-enable, 2-ce latency.
module charmap_pipe #(
  parameter int unsigned COLS_LOG2       = 6,
  parameter int unsigned ROWS_LOG2       = 6,
  parameter int unsigned CHAR_H_LOG2     = 3,
  parameter logic [7:0]  TRANSPARENT_KEY = 8'hC7
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ce_pix,
  input  logic [8:0]                        hcnt,
  input  logic [8:0]                        vcnt,
  input  logic                              hblank,
  input  logic                              vblank,
  input  logic [COLS_LOG2+2:0]              scroll_x,
  input  logic [ROWS_LOG2+CHAR_H_LOG2-1:0]  scroll_y,
  output logic [ROWS_LOG2+COLS_LOG2-1:0]    chram_addr,
  input  logic [7:0]                        chmap_data_out,
  input  logic [7:0]                        fgcolram_data_out,
  input  logic [7:0]                        bgcolram_data_out,
  output logic [7+CHAR_H_LOG2:0]            chrom_addr,
  input  logic [7:0]                        chrom_data_out,
  output logic [7:0]                        r,
  output logic [7:0]                        g,
  output logic [7:0]                        b,
  output logic                              a,
  output logic                              de
);

  localparam int unsigned XW = COLS_LOG2 + 3;
  localparam int unsigned YW = ROWS_LOG2 + CHAR_H_LOG2;

  logic [XW-1:0]                     sx_q, ex;
  logic [YW-1:0]                     sy_q, ey;
  logic                              vbl_q;

  logic [ROWS_LOG2+COLS_LOG2-1:0]    chram_addr_q;
  logic [2:0]                        px1_q;
  logic [CHAR_H_LOG2-1:0]            line1_q;
  logic                              vis1_q;

  logic [7+CHAR_H_LOG2:0]            chrom_addr_q;
  logic [7:0]                        fg2_q, bg2_q;
  logic [2:0]                        px2_q;
  logic                              vis2_q;

  logic [7:0]                        r_q, g_q, b_q, r_d, g_d, b_d;
  logic                              a_q, de_q, a_d, de_d;
  logic                              pix;
  logic [7:0]                        col;

  // Upper raster bits are dropped before the add so the map wraps per axis.
  assign ex = XW'(hcnt) + sx_q;
  assign ey = YW'(vcnt) + sy_q;

  always_comb begin
    pix  = chrom_data_out[3'd7 - px2_q];
    col  = pix ? fg2_q : bg2_q;
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    a_d  = 1'b0;
    de_d = 1'b0;
    if (vis2_q) begin
      r_d  = {col[2:0], col[2:0], 2'b00};
      g_d  = {col[5:3], col[5:3], 2'b00};
      b_d  = {col[7:6], col[7:6], col[7:6], 2'b00};
      a_d  = pix | (bg2_q != TRANSPARENT_KEY);
      de_d = 1'b1;
    end
  end

  // Visibility is carried active-high so the all-zero reset state reads as
  // blank, keeping pre-reset pipeline contents off the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sx_q         <= '0;
      sy_q         <= '0;
      vbl_q        <= 1'b0;
      chram_addr_q <= '0;
      px1_q        <= '0;
      line1_q      <= '0;
      vis1_q       <= 1'b0;
      chrom_addr_q <= '0;
      fg2_q        <= '0;
      bg2_q        <= '0;
      px2_q        <= '0;
      vis2_q       <= 1'b0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      a_q          <= 1'b0;
      de_q         <= 1'b0;
    end else begin
      vbl_q <= vblank;
      if (vblank && !vbl_q) begin
        sx_q <= scroll_x;
        sy_q <= scroll_y;
      end
      if (ce_pix) begin
        chram_addr_q <= {ey[YW-1:CHAR_H_LOG2], ex[XW-1:3]};
        px1_q        <= ex[2:0];
        line1_q      <= ey[CHAR_H_LOG2-1:0];
        vis1_q       <= ~(hblank | vblank);
        chrom_addr_q <= {chmap_data_out, line1_q};
        fg2_q        <= fgcolram_data_out;
        bg2_q        <= bgcolram_data_out;
        px2_q        <= px1_q;
        vis2_q       <= vis1_q;
        r_q          <= r_d;
        g_q          <= g_d;
        b_q          <= b_d;
        a_q          <= a_d;
        de_q         <= de_d;
      end
    end
  end

  assign chram_addr = chram_addr_q;
  assign chrom_addr = chrom_addr_q;
  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;
  assign a          = a_q;
  assign de         = de_q;

endmodule

// File: tb/tb_charmap_pipe.sv
// Scoreboard bench for charmap_pipe: per-pixel expectations are queued when
// a pixel is driven and popped when it reaches the outputs two ce later.
module tb_charmap_pipe;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       a;
    logic       de;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset, ce_pix, hblank, vblank;
  logic [8:0]  hcnt, vcnt, scroll_x, scroll_y;
  logic [11:0] chram_addr;
  logic [10:0] chrom_addr;
  logic [7:0]  chmap_data_out, fgcolram_data_out, bgcolram_data_out, chrom_data_out;
  logic [7:0]  r, g, b;
  logic        a, de;

  logic [7:0]  chmap [4096];
  logic [7:0]  fgram [4096];
  logic [7:0]  bgram [4096];
  logic [7:0]  chrom [2048];

  pix_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [8:0]  m_sx, m_sy;
  logic        last_vb;
  logic [10:0] last_rom;
  logic [11:0] exp_ram;
  logic [10:0] exp_rom;

  always #5 clk = ~clk;

  // Memories present RAM[addr] to the stage that registers on the next ce.
  assign chmap_data_out    = chmap[chram_addr];
  assign fgcolram_data_out = fgram[chram_addr];
  assign bgcolram_data_out = bgram[chram_addr];
  assign chrom_data_out    = chrom[chrom_addr];

  charmap_pipe #(
    .COLS_LOG2      (6),
    .ROWS_LOG2      (6),
    .CHAR_H_LOG2    (3),
    .TRANSPARENT_KEY(8'hC7)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ce_pix           (ce_pix),
    .hcnt             (hcnt),
    .vcnt             (vcnt),
    .hblank           (hblank),
    .vblank           (vblank),
    .scroll_x         (scroll_x),
    .scroll_y         (scroll_y),
    .chram_addr       (chram_addr),
    .chmap_data_out   (chmap_data_out),
    .fgcolram_data_out(fgcolram_data_out),
    .bgcolram_data_out(bgcolram_data_out),
    .chrom_addr       (chrom_addr),
    .chrom_data_out   (chrom_data_out),
    .r                (r),
    .g                (g),
    .b                (b),
    .a                (a),
    .de               (de)
  );

  task automatic model(input logic [8:0] h, input logic [8:0] v, input logic hb, input logic vb,
                       output pix_t e, output logic [11:0] ra, output logic [10:0] rom);
    logic [8:0] exx, eyy;
    logic [7:0] code, gl, c;
    logic       p;
    exx  = h + m_sx;
    eyy  = v + m_sy;
    ra   = {eyy[8:3], exx[8:3]};
    code = chmap[ra];
    rom  = {code, eyy[2:0]};
    gl   = chrom[rom];
    p    = gl[7 - exx[2:0]];
    c    = p ? fgram[ra] : bgram[ra];
    if (hb || vb) e = '0;
    else e = '{r: {c[2:0], c[2:0], 2'b00}, g: {c[5:3], c[5:3], 2'b00},
               b: {c[7:6], c[7:6], c[7:6], 2'b00}, a: p | (bgram[ra] != 8'hC7), de: 1'b1};
  endtask

  task automatic sb_init();
    sb.delete();
    sb.push_back('0);
    sb.push_back('0);
    m_sx     = '0;
    m_sy     = '0;
    last_vb  = 1'b0;
    last_rom = {chmap[0], 3'd0};
  endtask

  task automatic apply_reset();
    ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b0;
    reset  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    sb_init();
  endtask

  // Drives one pixel with ce_pix for one clock; returns queued and observed output.
  task automatic step(input logic [8:0] h, input logic [8:0] v, input logic hb, input logic vb,
                      output pix_t e, output pix_t got);
    pix_t        en;
    logic [11:0] ra;
    logic [10:0] rom;
    model(h, v, hb, vb, en, ra, rom);
    sb.push_back(en);
    exp_ram  = ra;
    exp_rom  = last_rom;
    last_rom = rom;
    if (vb && !last_vb) begin
      m_sx = scroll_x;
      m_sy = scroll_y;
    end
    last_vb = vb;
    hcnt = h; vcnt = v; hblank = hb; vblank = vb; ce_pix = 1'b1;
    @(posedge clk); #1;
    ce_pix = 1'b0;
    got = {r, g, b, a, de};
    e   = sb.pop_front();
  endtask

  task automatic test_reset();
    pix_t e, got;
    sb_init();
    reset = 1'b0;
    repeat (6) begin
      hcnt = 9'($urandom); vcnt = 9'($urandom); hblank = 1'($urandom); vblank = 1'($urandom);
      scroll_x = 9'($urandom); scroll_y = 9'($urandom); ce_pix = 1'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if ({r, g, b, a, de} !== 26'd0) begin
      errors++; $display("FAIL reset_pix: got %h exp 0", {r, g, b, a, de});
    end
    checks++;
    if (chram_addr !== 12'd0) begin
      errors++; $display("FAIL reset_chram: got %h exp 0", chram_addr);
    end
    checks++;
    if (chrom_addr !== 11'd0) begin
      errors++; $display("FAIL reset_chrom: got %h exp 0", chrom_addr);
    end
    hblank = 1'b0; vblank = 1'b0; scroll_x = '0; scroll_y = '0; ce_pix = 1'b0;
    reset = 1'b1;
    step(9'($urandom), 9'($urandom), 1'b0, 1'b0, e, got);
    checks++;
    if (got !== 26'd0 || e !== 26'd0) begin
      errors++; $display("FAIL reset_release: got %h exp 0", got);
    end
  endtask

  task automatic test_basic_fetch();
    pix_t e, got;
    apply_reset();
    step(9'd9, 9'd2, 1'b0, 1'b0, e, got);
    checks++;
    if (chram_addr !== 12'd1) begin
      errors++; $display("FAIL basic_chram: got %h exp 001", chram_addr);
    end
    step(9'd9, 9'd2, 1'b0, 1'b0, e, got);
    checks++;
    if (chrom_addr !== {8'h41, 3'd2}) begin
      errors++; $display("FAIL basic_chrom: got %h exp %h", chrom_addr, {8'h41, 3'd2});
    end
    step(9'd9, 9'd2, 1'b0, 1'b0, e, got);
    checks++;
    if (got !== {8'hFC, 8'hFC, 8'hFC, 1'b1, 1'b1}) begin
      errors++; $display("FAIL basic_pix: got %h exp %h", got, {8'hFC, 8'hFC, 8'hFC, 1'b1, 1'b1});
    end
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL basic_sb: got %h exp %h", got, e);
    end
  endtask

  task automatic test_transparency();
    pix_t e, got;
    apply_reset();
    step(9'd16, 9'd0, 1'b0, 1'b0, e, got);
    step(9'd24, 9'd0, 1'b0, 1'b0, e, got);
    step(9'd0, 9'd0, 1'b0, 1'b0, e, got);
    checks++;
    if (got !== {8'hFC, 8'h00, 8'hFC, 1'b0, 1'b1}) begin
      errors++; $display("FAIL transp_key: got %h exp %h", got, {8'hFC, 8'h00, 8'hFC, 1'b0, 1'b1});
    end
    step(9'd0, 9'd0, 1'b0, 1'b0, e, got);
    checks++;
    if (got !== {8'hD8, 8'h00, 8'hFC, 1'b1, 1'b1}) begin
      errors++; $display("FAIL transp_c6: got %h exp %h", got, {8'hD8, 8'h00, 8'hFC, 1'b1, 1'b1});
    end
  endtask

  task automatic test_scroll();
    pix_t e, got;
    apply_reset();
    scroll_x = 9'h1FF; scroll_y = 9'd8;
    step(9'd8, 9'd0, 1'b0, 1'b0, e, got);
    checks++;
    if (chram_addr !== 12'd1) begin
      errors++; $display("FAIL scroll_midframe: got %h exp 001", chram_addr);
    end
    step(9'd8, 9'd0, 1'b0, 1'b1, e, got);
    checks++;
    if (chram_addr !== 12'd1) begin
      errors++; $display("FAIL scroll_rise_edge: got %h exp 001", chram_addr);
    end
    step(9'd1, 9'd0, 1'b0, 1'b0, e, got);
    checks++;
    if (chram_addr !== 12'd64) begin
      errors++; $display("FAIL scroll_x_wrap0: got %h exp 040", chram_addr);
    end
    step(9'd0, 9'd504, 1'b0, 1'b0, e, got);
    checks++;
    if (chram_addr !== 12'd63) begin
      errors++; $display("FAIL scroll_row_wrap: got %h exp 03f", chram_addr);
    end
    step(9'd0, 9'd496, 1'b0, 1'b0, e, got);
    checks++;
    if (chram_addr !== 12'hFFF) begin
      errors++; $display("FAIL scroll_row63: got %h exp fff", chram_addr);
    end
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL scroll_sb: got %h exp %h", got, e);
    end
    scroll_x = '0; scroll_y = '0;
  endtask

  task automatic test_sparse_ce();
    pix_t e, got;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      step(9'd9, 9'd2, 1'b0, 1'b0, e, got);
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL sparse_sb[%0d]: got %h exp %h", k, got, e);
      end
      if (k == 2) begin
        checks++;
        if (got !== {8'hFC, 8'hFC, 8'hFC, 1'b1, 1'b1}) begin
          errors++; $display("FAIL sparse_pix: got %h exp fcfcfc11", got);
        end
      end
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        checks++;
        if ({r, g, b, a, de} !== got || chram_addr !== exp_ram || chrom_addr !== exp_rom) begin
          errors++;
          $display("FAIL sparse_hold[%0d.%0d]: got %h/%h/%h exp %h/%h/%h",
                   k, i, {r, g, b, a, de}, chram_addr, chrom_addr, got, exp_ram, exp_rom);
        end
      end
    end
  endtask

  task automatic test_blank_and_reset();
    pix_t e, got;
    apply_reset();
    step(9'd9, 9'd2, 1'b0, 1'b0, e, got);
    step(9'd9, 9'd2, 1'b1, 1'b0, e, got);
    step(9'd9, 9'd2, 1'b0, 1'b0, e, got);
    checks++;
    if (got !== {8'hFC, 8'hFC, 8'hFC, 1'b1, 1'b1}) begin
      errors++; $display("FAIL blank_pre: got %h exp fcfcfc11", got);
    end
    step(9'd9, 9'd2, 1'b0, 1'b0, e, got);
    checks++;
    if (got !== 26'd0 || e !== 26'd0) begin
      errors++; $display("FAIL blank_hb: got %h exp 0", got);
    end
    step(9'd9, 9'd2, 1'b0, 1'b0, e, got);
    checks++;
    if (got !== {8'hFC, 8'hFC, 8'hFC, 1'b1, 1'b1}) begin
      errors++; $display("FAIL blank_post: got %h exp fcfcfc11", got);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({r, g, b, a, de} !== 26'd0 || chram_addr !== 12'd0 || chrom_addr !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got %h/%h/%h exp 0", {r, g, b, a, de}, chram_addr, chrom_addr);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    sb_init();
    for (int k = 0; k < 3; k++) begin
      step(9'd16, 9'd0, 1'b0, 1'b0, e, got);
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL post_reset[%0d]: got %h exp %h", k, got, e);
      end
    end
    checks++;
    if (got !== {8'hFC, 8'h00, 8'hFC, 1'b0, 1'b1}) begin
      errors++; $display("FAIL post_reset_pix: got %h exp fc00fc01", got);
    end
  endtask

  task automatic test_back_to_back();
    pix_t e, got;
    apply_reset();
    for (int k = 0; k < 60; k++) begin
      scroll_x = 9'($urandom);
      scroll_y = 9'($urandom);
      step(9'($urandom), 9'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
           e, got);
      checks++;
      if (got !== e || chram_addr !== exp_ram || chrom_addr !== exp_rom) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h/%h/%h exp %h/%h/%h",
                 k, got, chram_addr, chrom_addr, e, exp_ram, exp_rom);
      end
    end
    vblank = 1'b0; hblank = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int unsigned i = 0; i < 4096; i++) begin
      chmap[i] = 8'(i * 37 + 11);
      fgram[i] = 8'(i * 5 + 1);
      bgram[i] = (i % 5 == 0) ? 8'hC7 : 8'(i * 3 + 2);
    end
    for (int unsigned i = 0; i < 2048; i++) chrom[i] = 8'(i * 29 + 7);
    chmap[1] = 8'h41; fgram[1] = 8'hFF; chrom[11'h20A] = 8'h40;
    chmap[2] = 8'h10; bgram[2] = 8'hC7;
    chmap[3] = 8'h10; bgram[3] = 8'hC6; chrom[11'h080] = 8'h00;
    reset = 1'b0; ce_pix = 1'b0; hcnt = '0; vcnt = '0;
    hblank = 1'b0; vblank = 1'b0; scroll_x = '0; scroll_y = '0;
    #2;
    test_reset();
    test_basic_fetch();
    test_transparency();
    test_scroll();
    test_sparse_ce();
    test_blank_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
